// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and default width for serial_sub
package serial_sub_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - one-bit combinational full subtractor
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial unsigned subtractor, LSB first; SERIAL_SUB_OVF_EN adds ovf
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             d_bit;
  logic             bout_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_sub u_full_sub (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (bin_q),
    .diff(d_bit),
    .bout(bout_bit)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = d_bit;
        bin_d            = bout_bit;
        cnt_d            = cnt_q + CW'(1);
        // Last bit: publish the completed result together with the final borrow.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          diff_d   = res_d;
          borrow_d = bout_bit;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = bin_q ^ bout_bit;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - randomized self-checking bench for serial_sub at WIDTH 8, 4 and 1
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start4 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy8, done8, bor8, busy4, done4, bor4, busy1, done1, bor1;
  logic [7:0] diff8;
  logic [3:0] diff4;
  logic [0:0] diff1;
  logic       ovf8, ovf4, ovf1;
  int         vec = 0;
  int         miss = 0;

  typedef struct {
    logic [63:0] d;
    logic        br;
    logic        ov;
  } res_t;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bor4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bor1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  // Reference: plain modular arithmetic plus the textbook signed-overflow rule.
  function automatic res_t model(input int w, input logic [63:0] av, input logic [63:0] bv);
    res_t r;
    logic [63:0] m;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r.d  = (av - bv) & m;
    r.br = (av < bv);
    r.ov = (av[w-1] != bv[w-1]) && (r.d[w-1] != av[w-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv);
    res_t r;
    int   early;
    r = model(8, {56'd0, av}, {56'd0, bv});
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    early = 0;
    for (int i = 1; i <= 8; i++) begin
      if (done8 || !busy8) early++;
      tick();
    end
    chk("w8_no_early_done", 64'(early), 64'd0);
    chk("w8_done", {63'd0, done8}, 64'd1);
    chk("w8_diff", {56'd0, diff8}, r.d);
    chk("w8_borrow", {63'd0, bor8}, {63'd0, r.br});
`ifdef SERIAL_SUB_OVF_EN
    chk("w8_ovf", {63'd0, ovf8}, {63'd0, r.ov});
`endif
    tick();
    chk("w8_idle_after", {62'd0, busy8, done8}, 64'd0);
    chk("w8_diff_hold", {56'd0, diff8}, r.d);
  endtask

  task automatic op_small(input int w, input int av, input int bv);
    res_t r;
    int   lat;
    logic dn;
    r = model(w, 64'(av), 64'(bv));
    if (w == 4) begin a4 = 4'(av); b4 = 4'(bv); start4 = 1'b1; end
    else begin a1 = 1'(av); b1 = 1'(bv); start1 = 1'b1; end
    tick();
    start4 = 1'b0; start1 = 1'b0;
    a4 = ~a4; b4 = ~b4; a1 = ~a1; b1 = ~b1;
    lat = 1;
    dn = (w == 4) ? done4 : done1;
    while (!dn && lat < 20) begin
      tick();
      lat++;
      dn = (w == 4) ? done4 : done1;
    end
    if (w == 4) begin
      chk("w4_latency", 64'(lat), 64'd5);
      chk("w4_diff", {60'd0, diff4}, r.d);
      chk("w4_borrow", {63'd0, bor4}, {63'd0, r.br});
`ifdef SERIAL_SUB_OVF_EN
      chk("w4_ovf", {63'd0, ovf4}, {63'd0, r.ov});
`endif
    end else begin
      chk("w1_latency", 64'(lat), 64'd2);
      chk("w1_diff", {63'd0, diff1}, r.d);
      chk("w1_borrow", {63'd0, bor1}, {63'd0, r.br});
`ifdef SERIAL_SUB_OVF_EN
      chk("w1_ovf", {63'd0, ovf1}, {63'd0, r.ov});
`endif
    end
    tick();
  endtask

  initial begin
    res_t        r;
    logic [15:0] q[$];
    logic [15:0] ops;
    int          ndone;

    tick();
    tick();
    chk("rst_outputs", {52'd0, busy8, done8, diff8, bor8, ovf8}, 64'd0);
    rst_n = 1'b1;
    tick();

    op8(8'h05, 8'h03);
    op8(8'h03, 8'h05);
    op8(8'h80, 8'h01);
    op8(8'h00, 8'h00);
    op8(8'h7F, 8'hFF);
    op8(8'hFF, 8'hFF);
    for (int i = 0; i < 20; i++) op8(8'($urandom), 8'($urandom));

    // start held high: a new operation every WIDTH+2 cycles, operands taken at each accept edge
    ndone = 0;
    start8 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (c % 10 == 0) q.push_back({a8, b8});
      tick();
      chk("b2b_done_phase", {63'd0, done8}, {63'd0, (c % 10 == 8)});
      if (done8 && q.size() > 0) begin
        ndone++;
        ops = q.pop_front();
        r = model(8, {56'd0, ops[15:8]}, {56'd0, ops[7:0]});
        chk("b2b_diff", {56'd0, diff8}, r.d);
        chk("b2b_borrow", {63'd0, bor8}, {63'd0, r.br});
      end
    end
    start8 = 1'b0;
    tick();
    tick();
    chk("b2b_done_count", 64'(ndone), 64'd3);

    // reset in the fourth cycle of an operation
    op8(8'h80, 8'h01);
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_outputs", {52'd0, busy8, done8, diff8, bor8, ovf8}, 64'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    op8(8'hFF, 8'h01);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op_small(4, x, y);

    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        op_small(1, x, y);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
